// File: rtl/uart_pkg.sv
// Shared definitions for the ASCII sequencer: control characters,
// mode encodings, FSM states and the CR/LF phase flag.
package uart_pkg;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    localparam logic [1:0] MODE_UP       = 2'b00;
    localparam logic [1:0] MODE_DOWN     = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;
    localparam logic [1:0] MODE_REPEAT   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP
    } state_t;

    // Which part of the CR/LF tail the current word belongs to.
    typedef enum logic [1:0] {
        PH_NONE = 2'd0,
        PH_CR   = 2'd1,
        PH_LF   = 2'd2
    } phase_t;

endpackage

// File: rtl/ascii_seq_next.sv
// Next-word logic for the ASCII sequencer.
// Ports: word/dir/phase/mode_q in; next_word/dir/phase and next_wrap out.
module ascii_seq_next
    import uart_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] FIRST   = 8'd97,
    parameter logic [WIDTH-1:0] LAST    = 8'd122,
    parameter bit               NEWLINE = 1'b1
) (
    input  logic [WIDTH-1:0] word,
    input  logic             dir,
    input  phase_t           phase,
    input  logic [1:0]       mode_q,
    output logic [WIDTH-1:0] next_word,
    output logic             next_dir,
    output phase_t           next_phase,
    output logic             next_wrap
);

    localparam logic [WIDTH-1:0] ONE  = 1;
    localparam logic [WIDTH-1:0] CR_W = WIDTH'(CR);
    localparam logic [WIDTH-1:0] LF_W = WIDTH'(LF);

    logic [WIDTH-1:0] inc;
    logic [WIDTH-1:0] dec;

    assign inc = word + ONE;
    assign dec = word - ONE;

    // dir: 1 = counting up. Only ping-pong looks at it.
    always_comb begin
        next_word  = word;
        next_dir   = dir;
        next_phase = PH_NONE;
        next_wrap  = 1'b0;
        if (phase == PH_CR) begin
            next_word  = LF_W;
            next_phase = PH_LF;
        end else if (phase == PH_LF) begin
            unique case (mode_q)
                MODE_DOWN: begin
                    next_word = LAST;
                    next_wrap = 1'b1;
                end
                MODE_PINGPONG: begin
                    next_word = FIRST + ONE;
                    next_dir  = 1'b1;
                end
                MODE_UP, MODE_REPEAT: begin
                    next_word = FIRST;
                    next_wrap = 1'b1;
                end
            endcase
        end else begin
            unique case (mode_q)
                MODE_UP: begin
                    if (word != LAST) begin
                        next_word = inc;
                    end else if (NEWLINE) begin
                        next_word  = CR_W;
                        next_phase = PH_CR;
                    end else begin
                        next_word = FIRST;
                        next_wrap = 1'b1;
                    end
                end
                MODE_DOWN: begin
                    if (word != FIRST) begin
                        next_word = dec;
                    end else if (NEWLINE) begin
                        next_word  = CR_W;
                        next_phase = PH_CR;
                    end else begin
                        next_word = LAST;
                        next_wrap = 1'b1;
                    end
                end
                MODE_PINGPONG: begin
                    if (dir) begin
                        if (word == LAST) begin
                            next_word = dec;
                            next_dir  = 1'b0;
                            next_wrap = (dec == FIRST);
                        end else begin
                            next_word = inc;
                        end
                    end else if (word != FIRST) begin
                        next_word = dec;
                        next_wrap = (dec == FIRST);
                    end else if (NEWLINE) begin
                        // Bottom turn: CR/LF, then resume at FIRST+1.
                        next_word  = CR_W;
                        next_phase = PH_CR;
                    end else begin
                        next_word = inc;
                        next_dir  = 1'b1;
                    end
                end
                MODE_REPEAT: begin
                    next_word = word;
                end
            endcase
        end
    end

endmodule

// File: rtl/ascii_seq_gen.sv
// ASCII character sequencer paced by a UART busy flag.
// Ports: clk, rst, enable, mode, tx_busy in; word, start, wrap, active out.
module ascii_seq_gen
    import uart_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] FIRST        = 8'd97,
    parameter logic [WIDTH-1:0] LAST         = 8'd122,
    parameter bit               NEWLINE      = 1'b1,
    parameter int               GAP_CYCLES   = 0,
    parameter int               BUSY_TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             tx_busy,
    output logic [WIDTH-1:0] word,
    output logic             start,
    output logic             wrap,
    output logic             active
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [GW-1:0] GAP_LAST =
        GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TW-1:0] TO_LAST =
        TW'((BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0);
    localparam logic [GW-1:0] G_ONE = 1;
    localparam logic [TW-1:0] T_ONE = 1;

    state_t           state;
    state_t           state_nx;
    logic [1:0]       mode_q;
    logic             dir;
    phase_t           phase;
    logic             wrap_q;
    logic [GW-1:0]    gap_cnt;
    logic [TW-1:0]    to_cnt;
    logic             gap_done;
    logic             advance;
    logic [WIDTH-1:0] nx_word;
    logic             nx_dir;
    phase_t           nx_phase;
    logic             nx_wrap;

    ascii_seq_next #(
        .WIDTH   (WIDTH),
        .FIRST   (FIRST),
        .LAST    (LAST),
        .NEWLINE (NEWLINE)
    ) u_next (
        .word       (word),
        .dir        (dir),
        .phase      (phase),
        .mode_q     (mode_q),
        .next_word  (nx_word),
        .next_dir   (nx_dir),
        .next_phase (nx_phase),
        .next_wrap  (nx_wrap)
    );

    // With no gap configured a GAP visit (after a timeout) lasts one cycle.
    assign gap_done = (GAP_CYCLES == 0) || (gap_cnt == GAP_LAST);
    assign advance  = ((state == ST_WAIT_DONE) && !tx_busy && (GAP_CYCLES == 0))
                   || ((state == ST_GAP) && gap_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (enable) state_nx = ST_SEND;
            end
            ST_SEND: begin
                state_nx = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nx = ST_WAIT_DONE;
                end else if (to_cnt == TO_LAST) begin
                    state_nx = ST_GAP;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (advance) begin
                        state_nx = enable ? ST_SEND : ST_IDLE;
                    end else begin
                        state_nx = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (advance) state_nx = enable ? ST_SEND : ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        start  = (state == ST_SEND);
        wrap   = (state == ST_SEND) && wrap_q;
        active = (state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word    <= FIRST;
            dir     <= 1'b1;
            phase   <= PH_NONE;
            mode_q  <= MODE_UP;
            wrap_q  <= 1'b0;
            gap_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            if ((state == ST_IDLE) && enable) begin
                mode_q <= mode;
                word   <= (mode == MODE_DOWN) ? LAST : FIRST;
                dir    <= (mode != MODE_DOWN);
                phase  <= PH_NONE;
                wrap_q <= 1'b1;
            end else if (advance && enable) begin
                word   <= nx_word;
                dir    <= nx_dir;
                phase  <= nx_phase;
                wrap_q <= nx_wrap;
            end
            to_cnt  <= (state == ST_WAIT_BUSY) ? to_cnt + T_ONE : '0;
            gap_cnt <= (state == ST_GAP) ? gap_cnt + G_ONE : '0;
        end
    end

endmodule

// File: tb/tb_ascii_seq_gen.sv
// Self-checking bench for ascii_seq_gen: three instances (up, ping-pong,
// down with gap) checked against a sequence/timing model.
module tb_ascii_seq_gen;

    localparam int NMAX = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]      rst;
    logic [2:0]      enable;
    logic [2:0][1:0] mode;
    logic [2:0]      tx_busy = '0;
    logic [2:0][7:0] word;
    logic [2:0]      start;
    logic [2:0]      wrap;
    logic [2:0]      active;
    logic [2:0]      tie0 = '0;

    ascii_seq_gen u_up (
        .clk(clk), .rst(rst[0]), .enable(enable[0]), .mode(mode[0]),
        .tx_busy(tx_busy[0]), .word(word[0]), .start(start[0]),
        .wrap(wrap[0]), .active(active[0])
    );

    ascii_seq_gen #(.FIRST(8'd65), .LAST(8'd68), .NEWLINE(1'b0)) u_pp (
        .clk(clk), .rst(rst[1]), .enable(enable[1]), .mode(mode[1]),
        .tx_busy(tx_busy[1]), .word(word[1]), .start(start[1]),
        .wrap(wrap[1]), .active(active[1])
    );

    ascii_seq_gen #(.GAP_CYCLES(3)) u_dn (
        .clk(clk), .rst(rst[2]), .enable(enable[2]), .mode(mode[2]),
        .tx_busy(tx_busy[2]), .word(word[2]), .start(start[2]),
        .wrap(wrap[2]), .active(active[2])
    );

    logic [7:0] exp_w  [3][NMAX];
    bit         exp_wr [3][NMAX];
    int exp_n[3];
    int base[3];
    int nstarts[3]  = '{0, 0, 0};
    int nwraps[3]   = '{0, 0, 0};
    int last_st[3]  = '{0, 0, 0};
    int prev_st[3]  = '{0, 0, 0};
    int rise_at[3]  = '{0, 0, 0};
    int fall_at[3]  = '{0, 0, 0};
    int fall_cyc[3] = '{0, 0, 0};
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic void push(int k, logic [7:0] v, bit w);
        if (exp_n[k] < NMAX) begin
            exp_w[k][exp_n[k]]  = v;
            exp_wr[k][exp_n[k]] = w;
            exp_n[k]++;
        end
    endfunction

    // Expected character stream as a list of passes; each pass's first
    // entry is a wrap.
    function automatic void build(int k, logic [1:0] m, int f, int l, bit nl);
        exp_n[k] = 0;
        base[k]  = nstarts[k];
        for (int p = 0; p < 12; p++) begin
            case (m)
                2'b00: begin
                    for (int c = f; c <= l; c++) push(k, 8'(c), c == f);
                    if (nl) begin
                        push(k, 8'h0D, 0);
                        push(k, 8'h0A, 0);
                    end
                end
                2'b01: begin
                    for (int c = l; c >= f; c--) push(k, 8'(c), c == l);
                    if (nl) begin
                        push(k, 8'h0D, 0);
                        push(k, 8'h0A, 0);
                    end
                end
                2'b10: begin
                    push(k, 8'(f), 1);
                    if (p > 0 && nl) begin
                        push(k, 8'h0D, 0);
                        push(k, 8'h0A, 0);
                    end
                    for (int c = f + 1; c <= l; c++) push(k, 8'(c), 0);
                    for (int c = l - 1; c > f; c--) push(k, 8'(c), 0);
                end
                default: push(k, 8'(f), p == 0);
            endcase
        end
    endfunction

    // UART model: busy for 10 cycles starting the cycle after start.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic b;
            if (start[k] === 1'b1 && !tie0[k]) begin
                rise_at[k] = cyc + 1;
                fall_at[k] = cyc + 11;
            end
            b = (cyc >= rise_at[k]) && (cyc < fall_at[k]) && !tie0[k];
            if (tx_busy[k] && !b) fall_cyc[k] = cyc;
            tx_busy[k] = b;
        end
    end

    // Compare process: every start is checked against the model stream.
    always @(negedge clk) begin
        int j;
        for (int k = 0; k < 3; k++) begin
            if (start[k] === 1'b1) begin
                j = nstarts[k] - base[k];
                if (j < exp_n[k]) begin
                    chk($sformatf("word%0d[%0d]", k, j), word[k], exp_w[k][j]);
                    chk($sformatf("wrap%0d[%0d]", k, j), wrap[k], exp_wr[k][j]);
                end else begin
                    chk($sformatf("overrun%0d", k), j, exp_n[k] - 1);
                end
                chk($sformatf("active%0d", k), active[k], 1);
                if (k == 2 && j > 0)
                    chk("gap_spacing", cyc - fall_cyc[2], 4);
                prev_st[k] = last_st[k];
                last_st[k] = cyc;
                nstarts[k]++;
                if (wrap[k]) nwraps[k]++;
            end else begin
                chk($sformatf("wrap_idle%0d", k), wrap[k], 0);
            end
        end
    end

    task automatic wait_starts(input int k, input int n, input int budget);
        int t = 0;
        while (nstarts[k] < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("wait_starts%0d", k), int'(nstarts[k] >= n), 1);
    endtask

    task automatic wait_idle(input int k, input int budget);
        int t = 0;
        while (active[k] !== 1'b0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("wait_idle%0d", k), active[k], 0);
    endtask

    task automatic wait_pulse(input int k, input int budget);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (start[k] !== 1'b1 && t < budget);
        chk($sformatf("wait_pulse%0d", k), start[k], 1);
    endtask

    int n0;
    logic [7:0] pp_ref [8];

    initial begin
        rst    = '1;
        enable = '0;
        mode   = '0;
        repeat (2) @(negedge clk);
        chk("rst_word", word[0], 97);
        chk("rst_start", start[0], 0);
        chk("rst_wrap", wrap[0], 0);
        chk("rst_active", active[0], 0);
        chk("rst_word_pp", word[1], 65);
        rst = '0;

        build(0, 2'b00, 97, 122, 1);
        build(1, 2'b10, 65, 68, 0);
        build(2, 2'b01, 97, 122, 1);
        chk("model_up_cr", exp_w[0][26], 8'h0D);
        chk("model_up_lf", exp_w[0][27], 8'h0A);
        chk("model_up_wrapword", exp_w[0][28], 97);
        chk("model_up_wrapflag", exp_wr[0][28], 1);
        chk("model_up_nowrap", exp_wr[0][1], 0);
        pp_ref = '{8'd65, 8'd66, 8'd67, 8'd68, 8'd67, 8'd66, 8'd65, 8'd66};
        for (int i = 0; i < 8; i++)
            chk($sformatf("model_pp[%0d]", i), exp_w[1][i], pp_ref[i]);
        chk("model_dn_first", exp_w[2][0], 122);

        mode[0] = 2'b00;
        mode[1] = 2'b10;
        mode[2] = 2'b01;
        enable  = '1;
        wait_starts(0, 29, 29 * 12 + 20);
        enable = '0;
        chk("up_wrap_count", nwraps[0], 2);
        wait_idle(0, 40);
        wait_idle(1, 40);
        wait_idle(2, 40);
        chk("up_start_count", nstarts[0], 29);
        chk("pp_enough", int'(nstarts[1] >= 8), 1);
        chk("dn_enough", int'(nstarts[2] >= 3), 1);

        // Drop enable while word 100 is in flight.
        build(0, 2'b00, 97, 122, 1);
        n0 = nstarts[0];
        enable[0] = 1'b1;
        wait_starts(0, n0 + 4, 80);
        repeat (3) @(negedge clk);
        enable[0] = 1'b0;
        wait_idle(0, 30);
        chk("drop_word", word[0], 100);
        chk("drop_starts", nstarts[0] - n0, 4);

        build(0, 2'b01, 97, 122, 1);
        mode[0]   = 2'b01;
        enable[0] = 1'b1;
        wait_pulse(0, 10);
        chk("reen_word", word[0], 122);
        chk("reen_wrap", wrap[0], 1);

        // Reset while waiting for the transmitter to finish.
        repeat (4) @(negedge clk);
        enable[0] = 1'b0;
        rst[0]    = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("midrst_word", word[0], 97);
        chk("midrst_start", start[0], 0);
        chk("midrst_active", active[0], 0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("postrst_active", active[0], 0);
        end

        // Transmitter never responds: pacing comes from the timeout.
        tie0[0] = 1'b1;
        build(0, 2'b00, 97, 122, 1);
        mode[0]   = 2'b00;
        n0        = nstarts[0];
        enable[0] = 1'b1;
        wait_starts(0, n0 + 3, 40);
        chk("timeout_space_a", last_st[0] - prev_st[0], 6);
        wait_starts(0, n0 + 4, 20);
        chk("timeout_space_b", last_st[0] - prev_st[0], 6);
        enable[0] = 1'b0;
        wait_idle(0, 20);
        chk("timeout_word", word[0], 100);

        // Repeat mode.
        tie0[0] = 1'b0;
        repeat (12) @(negedge clk);
        build(0, 2'b11, 97, 122, 1);
        mode[0]   = 2'b11;
        n0        = nstarts[0];
        enable[0] = 1'b1;
        wait_starts(0, n0 + 3, 60);
        enable[0] = 1'b0;
        wait_idle(0, 30);
        chk("repeat_word", word[0], 97);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ascii_seq_gen.md
Name: ascii_seq_gen

Overview:
- Clocked, parametrised ASCII character sequencer that feeds the UART transmitter.
- Steps through a configurable code range in up, down or ping-pong order.
- Can append a CR/LF pair at each sequence wrap.
- Paces output against the transmitter's busy flag with a start/busy handshake and an optional inter-character gap, so no character is lost or duplicated.

Parameters:
- WIDTH, 8, width of word and of the range limits.
- FIRST, 8'd97, lowest code emitted ('a').
- LAST, 8'd122, highest code emitted ('z'). Requires FIRST < LAST.
- NEWLINE, 1, when 1 emit 8'h0D then 8'h0A after each sequence wrap.
- GAP_CYCLES, 0, idle clk cycles inserted after the transmitter finishes, before the next start.
- BUSY_TIMEOUT, 4, max cycles to wait for tx_busy to rise after start.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- enable, input, 1, run the sequence while high.
- mode, input, 2, 00 up, 01 down, 10 ping-pong, 11 repeat current code.
- tx_busy, input, 1, UART transmitter busy flag.
- word, output, WIDTH, character presented to the UART; stable from start until the next advance.
- start, output, 1, one-cycle pulse requesting transmission of word.
- wrap, output, 1, one-cycle pulse coincident with the start of the first character of a new pass.
- active, output, 1, high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst=1 at a clk edge) has priority over everything:
  - word=FIRST, start=0, wrap=0, active=0.
  - Direction register=up, state=IDLE.
  - Gap counter and timeout counter cleared.
  - Reset mid-transfer abandons the handshake immediately.
- States: IDLE, SEND, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - When enable=1, latch mode into mode_q.
  - Load word: LAST if mode_q=01, otherwise FIRST. Direction=up (down for mode 01).
  - Next state SEND. Mode changes outside IDLE are ignored.
- SEND:
  - Occupies one cycle. start=1 in that cycle.
  - wrap=1 if word is the pass's first code, including the very first character after IDLE.
  - Next state WAIT_BUSY.
- WAIT_BUSY:
  - On tx_busy=1, go to WAIT_DONE.
  - If tx_busy stays 0 for BUSY_TIMEOUT cycles, treat the character as sent and go to GAP.
- WAIT_DONE:
  - On tx_busy=0, go to GAP (or straight to advance if GAP_CYCLES=0).
- GAP:
  - Count GAP_CYCLES cycles, then advance.
  - Advance = compute next word per the sequence rules below; the new word is visible the same cycle the FSM returns to SEND.
  - If enable=0 at the advance point, go to IDLE instead (word keeps its last value). The in-flight character always completes.
- Sequence rules:
  - Up: FIRST..LAST, then (NEWLINE ? 0D, 0A,) FIRST.
  - Down: LAST..FIRST, then (NEWLINE ? 0D, 0A,) LAST.
  - Ping-pong: FIRST..LAST..FIRST+1, FIRST, ...
    - Endpoints are not repeated.
    - Direction flips when LAST or FIRST is reached.
    - CR/LF is inserted only before returning up from FIRST.
  - Repeat: word unchanged, never wraps, wrap=0 after the first character.
- Arithmetic: WIDTH-bit increment/decrement. Range limits are compared by equality, so no overflow can occur within [FIRST, LAST].
- CR/LF sub-sequence is tracked by a 2-bit phase flag, not by word value, so ranges containing 0x0D/0x0A behave correctly.
- tx_busy already high when entering WAIT_BUSY: proceed to WAIT_DONE next cycle.
- enable dropping during SEND/WAIT_*: no effect until the advance point.

Decomposition:
- Shared package uart_pkg holds:
  - CR=8'h0D, LF=8'h0A.
  - Mode encodings MODE_UP/DOWN/PINGPONG/REPEAT.
  - FSM state enum.
- One natural sub-module: ascii_seq_next.
  - Combinational next-word/direction/newline-phase logic; inputs word, dir, phase, mode_q.
  - Instantiated once.
  - The top holds the FSM, gap counter and timeout counter.

Test Plan:
- Default parameters, mode=00, tx_busy model rises 1 cycle after start and stays high 10 cycles:
  - Expect words 97..122, 0D, 0A, 97 in order.
  - Exactly one start per word; wrap on the two 97 starts only.
- Ping-pong with FIRST=65, LAST=68, NEWLINE=0 -> word sequence 65,66,67,68,67,66,65,66.
- Down with GAP_CYCLES=3 -> words 122,121,...; exactly 3 idle cycles between tx_busy falling and the next start.
- tx_busy tied 0, BUSY_TIMEOUT=4 -> starts spaced every 6 cycles (SEND + 4 timeout + advance); sequence still advances.
- enable dropped while WAIT_DONE on word 100:
  - Transmission completes and the FSM goes to IDLE with word=100.
  - Re-enable with mode=01 -> next start carries 122 with wrap=1.
- rst asserted during WAIT_DONE:
  - Next cycle word=97, start=0, active=0.
  - tx_busy activity is ignored until enable is high.
